// File: rtl/first_countdown_timer_pkg.sv
// Shared definitions for the countdown timer and its sibling blocks in the timing subsystem.
package first_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  // Default counter width, shared with the up-counter.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Terminal-compare constants; resized to the instance width at the point of use.
  localparam int unsigned CNT_ZERO = 0;
  localparam int unsigned CNT_ONE  = 1;

endpackage

// File: rtl/first_countdown_timer_if.sv
// Control/status bundle between a controller (master) and the countdown timer (slave).
interface first_countdown_timer_if #(
  parameter int unsigned WIDTH = first_countdown_timer_pkg::DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic             ack;
  logic [WIDTH-1:0] counter_out;
  logic             busy_out;
  logic             tc_pulse;
  logic             underflow_out;
  logic             missed_out;

  modport master (
    output load, load_value, enable, auto_reload, ack,
    input  counter_out, busy_out, tc_pulse, underflow_out, missed_out
  );

  modport slave (
    input  load, load_value, enable, auto_reload, ack,
    output counter_out, busy_out, tc_pulse, underflow_out, missed_out
  );

endinterface

// File: rtl/first_sticky_flag.sv
// Set/clear sticky flag with set priority and async active-high reset.
module first_sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o,
  output logic was_set_o
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;
  // A set arriving while the flag is already high: a repeated event.
  assign was_set_o = set_i & flag_q;

endmodule

// File: rtl/first_countdown_timer.sv
// Loadable down-counter with terminal-count pulse, optional auto-reload and sticky flags.
module first_countdown_timer
  import first_countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  first_countdown_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_Z = WIDTH'(CNT_ZERO);
  localparam logic [WIDTH-1:0] CNT_1 = WIDTH'(CNT_ONE);

  state_e           state_d,   state_q;
  logic [WIDTH-1:0] counter_d, counter_q;
  logic [WIDTH-1:0] reload_d,  reload_q;
  logic             busy_d,    busy_q;
  logic             tc_d,      tc_q;
  logic             missed_d,  missed_q;
  logic             terminal;
  logic             underflow;
  logic             was_set;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    terminal  = 1'b0;

    if (bus.load) begin
      reload_d  = bus.load_value;
      counter_d = bus.load_value;
      state_d   = (bus.load_value != CNT_Z) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          counter_d = counter_q;
        end
        ST_RUN: begin
          if (bus.enable) begin
            if (counter_q == CNT_1) begin
              terminal = 1'b1;
              tc_d     = 1'b1;
              if (bus.auto_reload) begin
                counter_d = reload_q;
              end else begin
                counter_d = CNT_Z;
                state_d   = ST_EXPIRED;
              end
            end else if (counter_q != CNT_Z) begin
              counter_d = counter_q - CNT_1;
            end
          end
        end
        ST_EXPIRED: begin
          counter_d = CNT_Z;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = CNT_Z;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // Ack clears missed; a terminal count racing with ack must not set it.
  always_comb begin
    missed_d = missed_q;
    if (bus.ack) begin
      missed_d = 1'b0;
    end else if (was_set) begin
      missed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      busy_q    <= 1'b0;
      tc_q      <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      tc_q      <= tc_d;
      missed_q  <= missed_d;
    end
  end

  first_sticky_flag u_underflow (
    .clk       (clk),
    .reset     (reset),
    .set_i     (terminal),
    .clr_i     (bus.ack),
    .flag_o    (underflow),
    .was_set_o (was_set)
  );

  assign bus.counter_out   = counter_q;
  assign bus.busy_out      = busy_q;
  assign bus.tc_pulse      = tc_q;
  assign bus.underflow_out = underflow;
  assign bus.missed_out    = missed_q;

endmodule

// File: tb/tb_first_countdown_timer.sv
// Directed bench for first_countdown_timer: vector table plus hand-written multi-cycle sequences.
module tb_first_countdown_timer;

  localparam int unsigned W = 4;

  logic clk;
  logic reset;

  first_countdown_timer_if #(.WIDTH(W)) tif ();

  first_countdown_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         ar;
    logic         ak;
    logic [W-1:0] e_cnt;
    logic         e_busy;
    logic         e_tc;
    logic         e_uf;
    logic         e_miss;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic en,
                              input logic ar, input logic ak, input logic [W-1:0] c,
                              input logic b, input logic t, input logic u, input logic m);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.ar = ar; v.ak = ak;
    v.e_cnt = c; v.e_busy = b; v.e_tc = t; v.e_uf = u; v.e_miss = m;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic en,
                       input logic ar, input logic ak);
    tif.load        = ld;
    tif.load_value  = lv;
    tif.enable      = en;
    tif.auto_reload = ar;
    tif.ack         = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".cnt"},  32'(tif.counter_out), 32'd0);
    chk({nm, ".busy"}, 32'(tif.busy_out), 32'd0);
    chk({nm, ".tc"},   32'(tif.tc_pulse), 32'd0);
    chk({nm, ".uf"},   32'(tif.underflow_out), 32'd0);
    chk({nm, ".miss"}, 32'(tif.missed_out), 32'd0);
  endtask

  int tc_idx [3];
  int tc_cnt;
  int zero_seen;

  initial begin
    // Fields: ld lv en ar ak | cnt busy tc uf miss
    // One-shot from 3
    vecs[0]  = mk(1, 4'd3, 1, 0, 0, 4'd3, 1, 0, 0, 0);
    vecs[1]  = mk(0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0, 0);
    vecs[2]  = mk(0, 4'd0, 1, 0, 0, 4'd1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 1, 0);
    vecs[4]  = mk(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1, 0);
    vecs[5]  = mk(0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 1, 0);
    // Ack in EXPIRED, then auto-reload of 2 with an enable gap
    vecs[6]  = mk(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 4'd2, 1, 1, 0, 4'd2, 1, 0, 0, 0);
    vecs[8]  = mk(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 4'd0, 0, 1, 0, 4'd1, 1, 0, 0, 0);
    vecs[10] = mk(0, 4'd0, 1, 1, 0, 4'd2, 1, 1, 1, 0);
    vecs[11] = mk(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, 1, 0);
    vecs[12] = mk(0, 4'd0, 1, 1, 0, 4'd2, 1, 1, 1, 1);
    // Lone ack clears both flags
    vecs[13] = mk(0, 4'd0, 0, 1, 1, 4'd2, 1, 0, 0, 0);
    vecs[14] = mk(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, 0, 0);
    vecs[15] = mk(0, 4'd0, 1, 1, 0, 4'd2, 1, 1, 1, 0);
    vecs[16] = mk(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, 1, 0);
    // Ack on the terminal edge: set wins, missed stays 0
    vecs[17] = mk(0, 4'd0, 1, 1, 1, 4'd2, 1, 1, 1, 0);
    vecs[18] = mk(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, 1, 0);
    // Load at counter==1 beats terminal count; flags untouched
    vecs[19] = mk(1, 4'd9, 1, 1, 0, 4'd9, 1, 0, 1, 0);
    vecs[20] = mk(1, 4'd0, 1, 1, 0, 4'd0, 0, 0, 1, 0);
    vecs[21] = mk(0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 1, 0);
    vecs[22] = mk(0, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0, 0);

    drive(0, '0, 0, 0, 0);
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    step();
    step();
    reset = 1'b0;
    chk_all_zero("reset_state");

    // Idle: enable without load does nothing
    drive(0, '0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d.cnt", i), 32'(tif.counter_out), 32'd0);
      chk($sformatf("idle%0d.busy", i), 32'(tif.busy_out), 32'd0);
    end

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar, vecs[i].ak);
      step();
      chk($sformatf("v%0d.cnt", i),  32'(tif.counter_out),   32'(vecs[i].e_cnt));
      chk($sformatf("v%0d.busy", i), 32'(tif.busy_out),      32'(vecs[i].e_busy));
      chk($sformatf("v%0d.tc", i),   32'(tif.tc_pulse),      32'(vecs[i].e_tc));
      chk($sformatf("v%0d.uf", i),   32'(tif.underflow_out), 32'(vecs[i].e_uf));
      chk($sformatf("v%0d.miss", i), 32'(tif.missed_out),    32'(vecs[i].e_miss));
    end

    // Full range: 15 with auto-reload, 45 enabled edges -> pulses after edges 15, 30, 45
    drive(1, 4'd15, 1, 1, 0);
    step();
    chk("full.load_cnt", 32'(tif.counter_out), 32'd15);
    drive(0, '0, 1, 1, 0);
    tc_cnt = 0;
    zero_seen = 0;
    tc_idx[0] = -1; tc_idx[1] = -1; tc_idx[2] = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (tif.tc_pulse === 1'b1) begin
        if (tc_cnt < 3) tc_idx[tc_cnt] = i;
        tc_cnt++;
      end
      if (tif.counter_out === '0) zero_seen++;
    end
    chk("full.tc_count", 32'(tc_cnt), 32'd3);
    chk("full.tc_first", 32'(tc_idx[0]), 32'd14);
    chk("full.tc_gap1", 32'(tc_idx[1] - tc_idx[0]), 32'd15);
    chk("full.tc_gap2", 32'(tc_idx[2] - tc_idx[1]), 32'd15);
    chk("full.zero_seen", 32'(zero_seen), 32'd0);
    chk("full.uf", 32'(tif.underflow_out), 32'd1);
    chk("full.miss", 32'(tif.missed_out), 32'd1);

    // Reset mid-count, between clock edges
    step();
    chk("mid.busy_before", 32'(tif.busy_out), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid");
    step();
    reset = 1'b0;
    drive(0, '0, 1, 1, 0);
    step();
    chk_all_zero("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
